// File: rtl/pipelined_cpu.sv
// rtl/pipelined_cpu.sv - four-stage IF/ID/EX/WB CPU with hazard interlock
// Define PIPELINED_CPU_FORWARD_EN to bypass the EX result into ID instead of stalling.
module pipelined_cpu #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 4 + 2*REG_ADDR_W + DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               out_valid_o,
  output logic               stall_o,
  output logic               halted_o
);

  localparam int NREG = 1 << REG_ADDR_W;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BGT  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_OUT  = 4'd11;
  localparam logic [3:0] OP_IN   = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

`ifdef PIPELINED_CPU_FORWARD_EN
  localparam logic L_FWD = 1'b1;
`else
  localparam logic L_FWD = 1'b0;
`endif

  logic [PC_W-1:0]       r_pc;
  logic [INSTR_W-1:0]    r_id_instr;
  logic [3:0]            r_ex_op;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic [DATA_W-1:0]     r_ex_imm;
  logic [DATA_W-1:0]     r_ex_a;
  logic [DATA_W-1:0]     r_ex_b;
  logic                  r_wb_wr;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_halted;
  logic [DATA_W-1:0]     r_regs [NREG];

  logic [3:0]            w_id_op;
  logic [REG_ADDR_W-1:0] w_id_rd;
  logic [REG_ADDR_W-1:0] w_id_ra;
  logic [REG_ADDR_W-1:0] w_id_rb;
  logic [REG_ADDR_W-1:0] w_id_bsel;
  logic [DATA_W-1:0]     w_id_imm;
  logic                  w_id_is_br;
  logic                  w_id_is_alu;
  logic                  w_id_use_a;
  logic                  w_id_use_b;
  logic [DATA_W-1:0]     w_id_a;
  logic [DATA_W-1:0]     w_id_b;

  logic [DATA_W-1:0]     w_ex_result;
  logic                  w_ex_wr;
  logic                  w_ex_taken;
  logic                  w_ex_out;
  logic                  w_ex_halt;
  logic [PC_W-1:0]       w_ex_target;

  logic                  w_hazard;
  logic                  w_flush;
  logic                  w_stall;

  assign w_id_op     = r_id_instr[INSTR_W-1 -: 4];
  assign w_id_rd     = r_id_instr[INSTR_W-5 -: REG_ADDR_W];
  assign w_id_ra     = r_id_instr[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W];
  assign w_id_imm    = r_id_instr[DATA_W-1:0];
  assign w_id_rb     = w_id_imm[REG_ADDR_W-1:0];
  assign w_id_is_br  = (w_id_op == OP_BEQ) || (w_id_op == OP_BGT);
  assign w_id_is_alu = (w_id_op >= OP_ADD) && (w_id_op <= OP_XOR);
  assign w_id_use_a  = w_id_is_alu || w_id_is_br || (w_id_op == OP_ADDI) || (w_id_op == OP_OUT);
  assign w_id_use_b  = w_id_is_alu || w_id_is_br;
  // Branches compare ra against rd, so rd takes the second read port.
  assign w_id_bsel   = w_id_is_br ? w_id_rd : w_id_rb;

  always_comb begin
    w_id_a = r_regs[w_id_ra];
    if (w_id_ra == '0)
      w_id_a = '0;
    else if (L_FWD && w_ex_wr && (r_ex_rd == w_id_ra))
      w_id_a = w_ex_result;
    else if (r_wb_wr && (r_wb_rd == w_id_ra))
      w_id_a = r_wb_data;
  end

  always_comb begin
    w_id_b = r_regs[w_id_bsel];
    if (w_id_bsel == '0)
      w_id_b = '0;
    else if (L_FWD && w_ex_wr && (r_ex_rd == w_id_bsel))
      w_id_b = w_ex_result;
    else if (r_wb_wr && (r_wb_rd == w_id_bsel))
      w_id_b = r_wb_data;
  end

  assign w_ex_target = r_ex_imm[PC_W-1:0];

  always_comb begin
    w_ex_result = '0;
    w_ex_wr     = 1'b0;
    w_ex_taken  = 1'b0;
    w_ex_out    = 1'b0;
    w_ex_halt   = 1'b0;
    case (r_ex_op)
      OP_ADD:  begin w_ex_result = r_ex_a + r_ex_b;   w_ex_wr = 1'b1; end
      OP_SUB:  begin w_ex_result = r_ex_a - r_ex_b;   w_ex_wr = 1'b1; end
      OP_AND:  begin w_ex_result = r_ex_a & r_ex_b;   w_ex_wr = 1'b1; end
      OP_OR:   begin w_ex_result = r_ex_a | r_ex_b;   w_ex_wr = 1'b1; end
      OP_XOR:  begin w_ex_result = r_ex_a ^ r_ex_b;   w_ex_wr = 1'b1; end
      OP_LDI:  begin w_ex_result = r_ex_imm;          w_ex_wr = 1'b1; end
      OP_ADDI: begin w_ex_result = r_ex_a + r_ex_imm; w_ex_wr = 1'b1; end
      OP_BEQ:  w_ex_taken = (r_ex_a == r_ex_b);
      OP_BGT:  w_ex_taken = (r_ex_a > r_ex_b);
      OP_JMP:  w_ex_taken = 1'b1;
      OP_OUT:  w_ex_out = 1'b1;
      OP_IN:   begin w_ex_result = in_data_i;         w_ex_wr = 1'b1; end
      OP_HALT: w_ex_halt = 1'b1;
      default: ;
    endcase
    if (r_ex_rd == '0)
      w_ex_wr = 1'b0;
  end

  // One bubble suffices: the producer reaches WB next cycle and write-through covers it.
  assign w_hazard = w_ex_wr && ((w_id_use_a && (w_id_ra == r_ex_rd)) ||
                                (w_id_use_b && (w_id_bsel == r_ex_rd)));
  assign w_flush  = w_ex_taken || w_ex_halt || r_halted;
  assign w_stall  = !L_FWD && w_hazard && !w_flush;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_pc        <= '0;
      r_id_instr  <= '0;
      r_ex_op     <= OP_NOP;
      r_ex_rd     <= '0;
      r_ex_imm    <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_wb_wr     <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_halted    <= 1'b0;
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      if (r_wb_wr)
        r_regs[r_wb_rd] <= r_wb_data;
      r_wb_wr     <= w_ex_wr;
      r_wb_rd     <= r_ex_rd;
      r_wb_data   <= w_ex_result;
      r_out_valid <= w_ex_out;
      if (w_ex_out)
        r_out_data <= r_ex_a;
      if (w_ex_halt)
        r_halted <= 1'b1;

      if (w_flush || w_stall) begin
        r_ex_op  <= OP_NOP;
        r_ex_rd  <= '0;
        r_ex_imm <= '0;
        r_ex_a   <= '0;
        r_ex_b   <= '0;
      end else begin
        r_ex_op  <= w_id_op;
        r_ex_rd  <= w_id_rd;
        r_ex_imm <= w_id_imm;
        r_ex_a   <= w_id_a;
        r_ex_b   <= w_id_b;
      end

      if (w_flush) begin
        r_id_instr <= '0;
        if (w_ex_taken)
          r_pc <= w_ex_target;
      end else if (!w_stall) begin
        r_id_instr <= imem_data_i;
        r_pc       <= r_pc + 1'b1;
      end
    end
  end

  assign imem_addr_o = r_pc;
  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign stall_o     = w_stall;
  assign halted_o    = r_halted;

endmodule

// File: tb/tb_pipelined_cpu.sv
// tb/tb_pipelined_cpu.sv - scoreboard bench for pipelined_cpu against an ISA-level model
// Expected OUT values come from a sequential interpreter of the loaded program.
module tb_pipelined_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [17:0] imem_data;
  logic [7:0]  in_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        stall;
  logic        halted;

  logic [17:0] mem [256];
  int          n_checks = 0;
  int          n_fails  = 0;
  int          exp_q [$];
  int          last_at3;
  int          first_at20;

`ifdef PIPELINED_CPU_FORWARD_EN
  localparam int EXP_STALL_ADD = 0;
`else
  localparam int EXP_STALL_ADD = 2;
`endif

  pipelined_cpu dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .imem_addr_o (imem_addr),
    .imem_data_i (imem_data),
    .in_data_i   (in_data),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .stall_o     (stall),
    .halted_o    (halted)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [17:0] enc(input int op, input int rd, input int ra, input int imm);
    logic [3:0] o;
    logic [2:0] d;
    logic [2:0] a;
    logic [7:0] i;
    o = op[3:0]; d = rd[2:0]; a = ra[2:0]; i = imm[7:0];
    return {o, d, a, i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [17:0] word);
    for (int i = 0; i < 256; i++) mem[i] = word;
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion.
  task automatic model_run(input logic [7:0] in_val);
    logic [7:0]  rf [8];
    logic [7:0]  pc;
    logic [17:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [7:0]  imm, a, b, res;
    bit          wr;
    for (int i = 0; i < 8; i++) rf[i] = 8'd0;
    pc = 8'd0;
    for (int step = 0; step < 1000; step++) begin
      ins = mem[pc];
      op = ins[17:14]; rd = ins[13:11]; ra = ins[10:8]; imm = ins[7:0]; rb = imm[2:0];
      a = rf[ra]; b = rf[rb]; res = 8'd0; wr = 1'b0;
      pc = pc + 8'd1;
      case (op)
        4'd1:  begin res = a + b;   wr = 1'b1; end
        4'd2:  begin res = a - b;   wr = 1'b1; end
        4'd3:  begin res = a & b;   wr = 1'b1; end
        4'd4:  begin res = a | b;   wr = 1'b1; end
        4'd5:  begin res = a ^ b;   wr = 1'b1; end
        4'd6:  begin res = imm;     wr = 1'b1; end
        4'd7:  begin res = a + imm; wr = 1'b1; end
        4'd8:  if (a == rf[rd]) pc = imm;
        4'd9:  if (a > rf[rd]) pc = imm;
        4'd10: pc = imm;
        4'd11: exp_q.push_back(int'(a));
        4'd12: begin res = in_val;  wr = 1'b1; end
        4'd15: return;
        default: ;
      endcase
      if (wr && rd != 3'd0) rf[rd] = res;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL out_unexpected: out_valid_o high with out_data_o=%0h, none required", out_data);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), e);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int budget, output int stalls);
    int cyc;
    bit done;
    cyc = 0; stalls = 0; done = 1'b0;
    last_at3 = -1; first_at20 = -1;
    while (!done) begin
      @(negedge clk);
      if (halted || cyc >= budget) begin
        done = 1'b1;
      end else begin
        if (stall) stalls++;
        if (imem_addr == 8'd3) last_at3 = cyc;
        if (imem_addr == 8'h20 && first_at20 < 0) first_at20 = cyc;
        cyc++;
      end
    end
    check("halt_reached", 32'(halted), 32'd1);
    repeat (4) @(negedge clk);
    check("pending_outs", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int st;
    int errs;
    int n, op, rd, ra, imm;
    logic [17:0] halt_w;
    halt_w = enc(15, 0, 0, 0);
    rst_n = 1'b0;
    in_data = 8'd0;
    fill(halt_w);
    fork
      monitor();
    join_none

    // LDI/LDI/ADD/OUT: single pulse of 8, stall count depends on build
    fill(halt_w);
    mem[0] = enc(6, 1, 0, 5);
    mem[1] = enc(6, 2, 0, 3);
    mem[2] = enc(1, 3, 1, 2);
    mem[3] = enc(11, 0, 3, 0);
    model_run(8'd0);
    do_reset();
    run_prog(100, st);
    check("stall_count_add", st, EXP_STALL_ADD);
    check("out_data_hold", 32'(out_data), 32'd8);

    // HALT after NOPs: PC freezes, trailing OUTs never retire
    fill(18'd0);
    mem[5] = halt_w;
    mem[6] = enc(11, 0, 0, 0);
    mem[7] = enc(11, 0, 0, 0);
    do_reset();
    run_prog(50, st);
    check("halt_pc", 32'(imem_addr), 32'd7);
    repeat (10) @(negedge clk);
    check("halt_pc_frozen", 32'(imem_addr), 32'd7);
    check("halted_hold", 32'(halted), 32'd1);

    // Reset state after activity
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Modulo wrap through ADDI
    fill(halt_w);
    mem[0] = enc(6, 1, 0, 8'hFF);
    mem[1] = enc(7, 1, 1, 1);
    mem[2] = enc(11, 0, 1, 0);
    model_run(8'd0);
    do_reset();
    run_prog(100, st);

    // r0 discards writes and never stalls
    fill(halt_w);
    mem[0] = enc(6, 0, 0, 7);
    mem[1] = enc(11, 0, 0, 0);
    model_run(8'd0);
    do_reset();
    run_prog(100, st);
    check("stall_count_r0", st, 32'd0);

    // Taken BEQ: both shadow OUTs flushed, target fetched 2 cycles after BEQ leaves ID
    fill(halt_w);
    mem[0] = enc(6, 1, 0, 4);
    mem[1] = enc(6, 2, 0, 4);
    mem[2] = enc(8, 2, 1, 8'h20);
    mem[3] = enc(11, 0, 1, 0);
    mem[4] = enc(11, 0, 2, 0);
    model_run(8'd0);
    do_reset();
    run_prog(100, st);
    check("branch_fetch_gap", first_at20 - last_at3, 32'd2);

    // Reset while ADD is in EX: nothing retires, r3 stays zero
    fill(halt_w);
    mem[0] = enc(6, 1, 0, 5);
    mem[1] = enc(6, 2, 0, 3);
    mem[2] = 18'd0;
    mem[3] = 18'd0;
    mem[4] = enc(1, 3, 1, 2);
    mem[5] = enc(11, 0, 3, 0);
    do_reset();
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    fill(halt_w);
    mem[0] = enc(11, 0, 3, 0);
    model_run(8'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("addr_after_midreset", 32'(imem_addr), 32'd0);
    check("valid_after_midreset", 32'(out_valid), 32'd0);
    run_prog(50, st);

    // All-NOP program: PC walks 0..FF and wraps
    fill(18'd0);
    do_reset();
    errs = 0;
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      if (32'(imem_addr) != (k % 256)) errs++;
      if (k == 255) check("pc_reaches_ff", 32'(imem_addr), 32'hFF);
      if (k == 256) check("pc_wraps", 32'(imem_addr), 32'h00);
    end
    check("pc_sequence_errs", errs, 32'd0);

    // Random forward-branching programs ending in OUT r1..r7
    for (int t = 0; t < 30; t++) begin
      fill(halt_w);
      n = $urandom_range(16, 32);
      for (int i = 0; i < n; i++) begin
        op = $urandom_range(0, 14);
        rd = $urandom_range(0, 7);
        ra = $urandom_range(0, 7);
        imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : $urandom_range(0, 7);
        if (op >= 8 && op <= 10) imm = $urandom_range(i + 1, n + 7);
        mem[i] = enc(op, rd, ra, imm);
      end
      for (int r = 1; r < 8; r++) mem[n + r - 1] = enc(11, 0, r, 0);
      in_data = 8'($urandom_range(0, 255));
      model_run(in_data);
      do_reset();
      run_prog(400, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pipelined_cpu.md
PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath and register width.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, register address width (2^REG_ADDR_W registers).
REQ-003 SHALL have parameter PC_W, default 8, program counter width; PC_W <= DATA_W.
REQ-004 SHALL have derived parameter INSTR_W = 4 + 2*REG_ADDR_W + DATA_W (default 18).
REQ-005 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port imem_addr_o  output  PC_W  instruction fetch address, equal to the PC.
REQ-008 SHALL have port imem_data_i  input  INSTR_W  instruction at imem_addr_o, valid in the same cycle.
REQ-009 SHALL have port in_data_i  input  DATA_W  external data sampled by IN.
REQ-010 SHALL have port out_data_o  output  DATA_W  data from the last OUT.
REQ-011 SHALL have port out_valid_o  output  1  one-cycle pulse per retired OUT.
REQ-012 SHALL have port stall_o  output  1  high during cycles when the hazard interlock holds IF/ID.
REQ-013 SHALL have port halted_o  output  1  high once HALT has executed.

Function
REQ-014 Instruction fields SHALL be: op = top 4 bits, then rd, then ra (REG_ADDR_W each), then imm = low DATA_W bits; rb = imm[REG_ADDR_W-1:0]; target = imm[PC_W-1:0].
REQ-015 Opcodes SHALL be: 0 NOP; 1 ADD rd=ra+rb; 2 SUB rd=ra-rb; 3 AND; 4 OR; 5 XOR; 6 LDI rd=imm; 7 ADDI rd=ra+imm; 8 BEQ (ra==rd); 9 BGT (ra>rd, unsigned); 10 JMP; 11 OUT out=ra; 12 IN rd=in_data_i; 13-14 NOP; 15 HALT.
REQ-016 Arithmetic SHALL be modulo 2^DATA_W with no carry/overflow state.
REQ-017 Register 0 SHALL read as zero; writes to it SHALL be discarded and SHALL NOT create hazards.
REQ-018 Pipeline SHALL be four stages IF, ID, EX, WB: fetched at cycle n, register written at the clock edge ending cycle n+3.
REQ-019 Register reads in ID SHALL see the value being written by WB in the same cycle (write-through).
REQ-020 PC SHALL increment by 1 per unstalled cycle and wrap from 2^PC_W-1 to 0.
REQ-021 Branches/JMP SHALL resolve in EX; when taken, PC <= target and the instructions in IF/ID and ID/EX SHALL become NOPs (2-cycle penalty); not-taken costs nothing.
REQ-022 in_data_i SHALL be sampled when IN is in EX.
REQ-023 out_valid_o/out_data_o SHALL be driven from the WB stage register: pulse in the cycle an OUT is in WB; out_data_o holds until the next OUT.
REQ-024 HALT in EX SHALL freeze the PC, flush IF/ID and ID/EX, and set halted_o from the next cycle until reset; the instruction already in WB SHALL complete.
REQ-025 A taken branch in EX and a stall condition in the same cycle SHALL resolve as the branch (flush wins; stall_o low).

Reset
REQ-026 With rst_n_i low at a rising edge: PC=0, all pipeline registers = NOP, all registers = 0, out_data_o=0, out_valid_o=0, stall_o=0, halted_o=0.
REQ-027 Reset mid-operation SHALL abandon all in-flight instructions with no register write or OUT pulse; fetch restarts at address 0 in the first cycle after reset deasserts.

Configuration
REQ-028 Macro PIPELINED_CPU_FORWARD_EN defined: the EX result SHALL be bypassed to ID operands; stall_o is constantly 0; back-to-back dependants run at 1 IPC.
REQ-029 Macro not defined: when an ID source (ADD-XOR: ra,rb; ADDI, OUT: ra; BEQ/BGT: ra,rd) equals a nonzero EX destination, IF and ID SHALL hold and a NOP SHALL enter EX for 1 cycle, with stall_o high.

Verification
REQ-030 Reset then LDI r1,5; LDI r2,3; ADD r3,r1,r2; OUT r3 -> out_valid_o single pulse, out_data_o=8; stall count 0 with FORWARD_EN, 2 without.
REQ-031 LDI r1,0xFF; ADDI r1,r1,1; OUT r1 -> out_data_o=0x00 (wrap).
REQ-032 LDI r1,4; LDI r2,4; BEQ r1,r2 -> 0x20; two following OUTs -> neither pulses; fetch resumes at 0x20 exactly 2 cycles after BEQ leaves ID.
REQ-033 LDI r0,7; OUT r0 -> out_data_o=0, no stall in either build.
REQ-034 Program of NOPs from address 0 -> imem_addr_o reaches 0xFF then 0x00; HALT -> halted_o high, imem_addr_o frozen, no later OUT.
REQ-035 rst_n_i low for one cycle while ADD is in EX -> no register write, no out_valid_o; imem_addr_o=0 after reset.
